// File: rtl/trap_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// trap_controller
//
// Machine-mode trap sequencer. It takes synchronous exceptions from the
// core's exception encoder and three level-sensitive interrupt lines. It
// commits mepc/mcause/mtval/mstatus, redirects fetch to mtvec, and handles
// mret by returning to mepc. It also owns the machine trap CSRs and serves
// their reads and writes on the CSR bus.
//
// Build option:
//   VECTORED_IRQ_EN - when defined, mtvec.MODE is writable. With MODE=1,
//                     interrupts vector to BASE + 4*cause. When undefined,
//                     MODE reads 2'b00 and every trap goes to BASE.
//
// Ports:
//   clk, reset_n           core clock, asynchronous active-low reset
//   exception_i            synchronous exception this cycle
//   exception_code_i       5-bit cause code (passed through unchecked)
//   exc_pc_i, exc_tval_i   faulting pc and trap value
//   mret_i                 mret retiring this cycle
//   irq_sw_i/irq_timer_i/irq_ext_i  level interrupt lines (MSIP/MTIP/MEIP)
//   irq_accept_i           pipeline at an instruction boundary
//   irq_pc_i               pc saved to mepc when an interrupt is taken
//   csr_we_i, csr_addr_i, csr_wdata_i   CSR write port
//   csr_rdata_o            combinational read of csr_addr_i (0 if not owned)
//   redirect_o             one-cycle fetch redirect + flush
//   redirect_pc_o          redirect target (0 when not redirecting)
//   busy_o                 high in TRAP/RET so the front end stalls
// ---------------------------------------------------------------------------
module trap_controller #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] MTVEC_RST = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            exception_i,
    input  logic [4:0]      exception_code_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic [XLEN-1:0] exc_tval_i,
    input  logic            mret_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    input  logic            irq_accept_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            csr_we_i,
    input  logic [11:0]     csr_addr_i,
    input  logic [XLEN-1:0] csr_wdata_i,
    output logic [XLEN-1:0] csr_rdata_o,
    output logic            redirect_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TRAP = 2'd1,
        ST_RET  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              mstatus_mie_q, mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    // Only the three implemented enables are stored: {MEIE, MTIE, MSIE}.
    logic [2:0]        mie_q, mie_d;
    logic [XLEN-3:0]   mtvec_base_q, mtvec_base_d;
`ifdef VECTORED_IRQ_EN
    logic              mtvec_mode_q, mtvec_mode_d;
`endif
    // mepc bits 1:0 always read zero, so only the upper bits are kept.
    logic [XLEN-3:0]   mepc_q, mepc_d;
    logic [XLEN-1:0]   mcause_q, mcause_d;
    logic [XLEN-1:0]   mtval_q, mtval_d;
    logic              redirect_q, redirect_d;
    logic              busy_q, busy_d;
    logic [XLEN-1:0]   redirect_pc_q, redirect_pc_d;

    logic [2:0]        mip_vec;
    logic [2:0]        irq_enabled;
    logic              irq_pending;
    logic [3:0]        irq_cause;
    logic              take_irq;
    logic [XLEN-1:0]   trap_target;

    assign mip_vec     = {irq_ext_i, irq_timer_i, irq_sw_i};
    assign irq_enabled = mie_q & mip_vec;
    assign irq_pending = mstatus_mie_q && (irq_enabled != 3'b000) && irq_accept_i;

    // Fixed interrupt priority: external, then software, then timer.
    always_comb begin
        if (irq_enabled[2]) begin
            irq_cause = 4'd11;
        end else if (irq_enabled[0]) begin
            irq_cause = 4'd3;
        end else begin
            irq_cause = 4'd7;
        end
    end

    // Next-state logic. CSR-bus writes are applied first, and a trap or mret
    // commit then overrides the trap CSRs, so the trap wins on a collision.
    // The registered outputs come from the next state, so redirect_o is high
    // for exactly the cycle spent in TRAP or RET.
    always_comb begin
        state_d        = state_q;
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_base_d   = mtvec_base_q;
`ifdef VECTORED_IRQ_EN
        mtvec_mode_d   = mtvec_mode_q;
`endif
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;
        redirect_d     = 1'b0;
        busy_d         = 1'b0;
        redirect_pc_d  = '0;
        take_irq       = 1'b0;

        if (csr_we_i) begin
            case (csr_addr_i)
                CSR_MSTATUS: begin
                    mstatus_mie_d  = csr_wdata_i[3];
                    mstatus_mpie_d = csr_wdata_i[7];
                end
                CSR_MIE:    mie_d        = {csr_wdata_i[11], csr_wdata_i[7], csr_wdata_i[3]};
                CSR_MTVEC: begin
                    mtvec_base_d = csr_wdata_i[XLEN-1:2];
`ifdef VECTORED_IRQ_EN
                    mtvec_mode_d = csr_wdata_i[0];
`endif
                end
                CSR_MEPC:   mepc_d       = csr_wdata_i[XLEN-1:2];
                CSR_MCAUSE: mcause_d     = csr_wdata_i;
                CSR_MTVAL:  mtval_d      = csr_wdata_i;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (exception_i) begin
                    state_d        = ST_TRAP;
                    mepc_d         = exc_pc_i[XLEN-1:2];
                    mcause_d       = {1'b0, {(XLEN-6){1'b0}}, exception_code_i};
                    mtval_d        = exc_tval_i;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                end else if (irq_pending) begin
                    state_d        = ST_TRAP;
                    take_irq       = 1'b1;
                    mepc_d         = irq_pc_i[XLEN-1:2];
                    mcause_d       = {1'b1, {(XLEN-5){1'b0}}, irq_cause};
                    mtval_d        = '0;
                    mstatus_mpie_d = mstatus_mie_q;
                    mstatus_mie_d  = 1'b0;
                end else if (mret_i) begin
                    state_d        = ST_RET;
                    mstatus_mie_d  = mstatus_mpie_q;
                    mstatus_mpie_d = 1'b1;
                end
            end
            // Younger work is being flushed, so every request is dropped here.
            ST_TRAP, ST_RET: state_d = ST_IDLE;
            default:         state_d = ST_IDLE;
        endcase

        // The target uses the mtvec value seen during the TRAP cycle, which
        // includes an mtvec write that lands on the same edge.
        trap_target = {mtvec_base_d, 2'b00};
`ifdef VECTORED_IRQ_EN
        if (mtvec_mode_d && take_irq) begin
            trap_target = trap_target + {{(XLEN-6){1'b0}}, irq_cause, 2'b00};
        end
`endif

        if (state_d == ST_TRAP) begin
            redirect_d    = 1'b1;
            busy_d        = 1'b1;
            redirect_pc_d = trap_target;
        end else if (state_d == ST_RET) begin
            redirect_d    = 1'b1;
            busy_d        = 1'b1;
            redirect_pc_d = {mepc_d, 2'b00};
        end
    end

    // State, trap CSRs and registered outputs in one clocked process.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= 3'b000;
            mtvec_base_q   <= MTVEC_RST[XLEN-1:2];
`ifdef VECTORED_IRQ_EN
            mtvec_mode_q   <= MTVEC_RST[0];
`endif
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            redirect_q     <= 1'b0;
            busy_q         <= 1'b0;
            redirect_pc_q  <= '0;
        end else begin
            state_q        <= state_d;
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_base_q   <= mtvec_base_d;
`ifdef VECTORED_IRQ_EN
            mtvec_mode_q   <= mtvec_mode_d;
`endif
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
            redirect_q     <= redirect_d;
            busy_q         <= busy_d;
            redirect_pc_q  <= redirect_pc_d;
        end
    end

    // CSR read mux. mstatus.MPP is hardwired to machine mode, and mip shows
    // the live interrupt lines rather than a latched copy.
    always_comb begin
        csr_rdata_o = '0;
        case (csr_addr_i)
            CSR_MSTATUS: begin
                csr_rdata_o[12:11] = 2'b11;
                csr_rdata_o[7]     = mstatus_mpie_q;
                csr_rdata_o[3]     = mstatus_mie_q;
            end
            CSR_MIE: begin
                csr_rdata_o[11] = mie_q[2];
                csr_rdata_o[7]  = mie_q[1];
                csr_rdata_o[3]  = mie_q[0];
            end
`ifdef VECTORED_IRQ_EN
            CSR_MTVEC:  csr_rdata_o = {mtvec_base_q, 1'b0, mtvec_mode_q};
`else
            CSR_MTVEC:  csr_rdata_o = {mtvec_base_q, 2'b00};
`endif
            CSR_MEPC:   csr_rdata_o = {mepc_q, 2'b00};
            CSR_MCAUSE: csr_rdata_o = mcause_q;
            CSR_MTVAL:  csr_rdata_o = mtval_q;
            CSR_MIP: begin
                csr_rdata_o[11] = irq_ext_i;
                csr_rdata_o[7]  = irq_timer_i;
                csr_rdata_o[3]  = irq_sw_i;
            end
            default: ;
        endcase
    end

    assign redirect_o    = redirect_q;
    assign busy_o        = busy_q;
    assign redirect_pc_o = redirect_pc_q;

endmodule

// File: tb/tb_trap_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_trap_controller
//
// Directed bench for trap_controller. A reference model of the machine trap
// rules runs alongside the DUT and is compared on every falling edge. Literal
// expectations at each step pin down the values the model should produce.
// ---------------------------------------------------------------------------
module tb_trap_controller;

    localparam int unsigned XLEN = 32;

`ifdef VECTORED_IRQ_EN
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFD;
`else
    localparam logic [31:0] MTVEC_MASK = 32'hFFFF_FFFC;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        exception_i = 1'b0;
    logic [4:0]  exception_code_i = '0;
    logic [31:0] exc_pc_i = '0;
    logic [31:0] exc_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        irq_sw_i = 1'b0;
    logic        irq_timer_i = 1'b0;
    logic        irq_ext_i = 1'b0;
    logic        irq_accept_i = 1'b0;
    logic [31:0] irq_pc_i = '0;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_addr_i = 12'h300;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    int errors = 0;
    int checks = 0;
    bit compare_en = 1'b0;

    // Reference state: architectural CSR contents plus the pending redirect.
    logic        m_mie, m_mpie;
    logic [31:0] m_mie_reg, m_mtvec, m_mepc, m_mcause, m_mtval;
    logic        m_redir;
    logic [31:0] m_target;

    always #10 clk = ~clk;

    trap_controller #(
        .XLEN      (XLEN),
        .MTVEC_RST (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .exception_i      (exception_i),
        .exception_code_i (exception_code_i),
        .exc_pc_i         (exc_pc_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .irq_sw_i         (irq_sw_i),
        .irq_timer_i      (irq_timer_i),
        .irq_ext_i        (irq_ext_i),
        .irq_accept_i     (irq_accept_i),
        .irq_pc_i         (irq_pc_i),
        .csr_we_i         (csr_we_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_rdata_o      (csr_rdata_o),
        .redirect_o       (redirect_o),
        .redirect_pc_o    (redirect_pc_o),
        .busy_o           (busy_o)
    );

    function automatic logic [31:0] mipNow();
        return (32'(irq_ext_i) << 11) | (32'(irq_timer_i) << 7) | (32'(irq_sw_i) << 3);
    endfunction

    function automatic logic [31:0] modelRead(input logic [11:0] addr);
        case (addr)
            12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
            12'h304: return m_mie_reg;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h343: return m_mtval;
            12'h344: return mipNow();
            default: return 32'h0;
        endcase
    endfunction

    task automatic modelReset();
        m_mie     = 1'b0;
        m_mpie    = 1'b0;
        m_mie_reg = '0;
        m_mtvec   = 32'h0;
        m_mepc    = '0;
        m_mcause  = '0;
        m_mtval   = '0;
        m_redir   = 1'b0;
        m_target  = '0;
    endtask

    // One clock of the trap rules: a redirect cycle swallows every request;
    // otherwise exception beats interrupt beats mret.
    task automatic modelStep();
        logic [31:0] enabled;
        bit          exc, irq, ret;
        int          code;
        enabled = m_mie_reg & mipNow();
        exc  = !m_redir && exception_i;
        irq  = !m_redir && !exc && m_mie && (enabled != 0) && irq_accept_i;
        ret  = !m_redir && !exc && !irq && mret_i;
        code = enabled[11] ? 11 : (enabled[3] ? 3 : 7);

        if (csr_we_i) begin
            case (csr_addr_i)
                12'h300: begin m_mie = csr_wdata_i[3]; m_mpie = csr_wdata_i[7]; end
                12'h304: m_mie_reg = csr_wdata_i & 32'h888;
                12'h305: m_mtvec   = csr_wdata_i & MTVEC_MASK;
                12'h341: m_mepc    = csr_wdata_i & 32'hFFFF_FFFC;
                12'h342: m_mcause  = csr_wdata_i;
                12'h343: m_mtval   = csr_wdata_i;
                default: ;
            endcase
        end

        if (exc || irq) begin
            m_mpie   = m_mie;
            m_mie    = 1'b0;
            m_mepc   = (exc ? exc_pc_i : irq_pc_i) & 32'hFFFF_FFFC;
            m_mcause = exc ? 32'(exception_code_i) : (32'h8000_0000 + 32'(code));
            m_mtval  = exc ? exc_tval_i : 32'h0;
        end else if (ret) begin
            m_mie  = m_mpie;
            m_mpie = 1'b1;
        end

        m_redir = exc || irq || ret;
        if (exc) begin
            m_target = m_mtvec & 32'hFFFF_FFFC;
        end else if (irq) begin
            m_target = m_mtvec & 32'hFFFF_FFFC;
            if (m_mtvec[1:0] == 2'b01) m_target = m_target + 32'(4 * code);
        end else if (ret) begin
            m_target = m_mepc;
        end else begin
            m_target = '0;
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) modelReset();
        else          modelStep();
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (compare_en) begin
            checkOutput("model redirect_o", 32'(redirect_o), 32'(m_redir));
            checkOutput("model busy_o", 32'(busy_o), 32'(m_redir));
            checkOutput("model redirect_pc_o", redirect_pc_o, m_redir ? m_target : 32'h0);
            checkOutput("model csr_rdata_o", csr_rdata_o, modelRead(csr_addr_i));
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic writeCsr(input logic [11:0] addr, input logic [31:0] data);
        csr_we_i    = 1'b1;
        csr_addr_i  = addr;
        csr_wdata_i = data;
        applyStimulus();
        csr_we_i    = 1'b0;
    endtask

    task automatic readCsr(input string name, input logic [11:0] addr, input logic [31:0] exp);
        csr_addr_i = addr;
        #1;
        checkOutput(name, csr_rdata_o, exp);
    endtask

    task automatic checkRedirect(input string name, input logic exp_redir, input logic [31:0] exp_pc);
        checkOutput({name, " redirect"}, 32'(redirect_o), 32'(exp_redir));
        checkOutput({name, " busy"}, 32'(busy_o), 32'(exp_redir));
        checkOutput({name, " pc"}, redirect_pc_o, exp_pc);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        modelReset();
        #1 reset_n = 1'b0;
        compare_en = 1'b1;
        #2;
        checkRedirect("reset", 1'b0, 32'h0);
        readCsr("reset mstatus", 12'h300, 32'h0000_1800);
        readCsr("reset mtvec", 12'h305, 32'h0);
        applyStimulus();
        applyStimulus();
        reset_n = 1'b1;
        applyStimulus();

        // ecall to mtvec=0x200; a second exception held into TRAP is dropped.
        writeCsr(12'h305, 32'h200);
        readCsr("mtvec write", 12'h305, 32'h200);
        exception_i = 1'b1; exception_code_i = 5'd11; exc_pc_i = 32'h100; exc_tval_i = 32'h0;
        applyStimulus();
        checkRedirect("ecall", 1'b1, 32'h200);
        exception_code_i = 5'd2; exc_pc_i = 32'h180;
        applyStimulus();
        exception_i = 1'b0;
        checkRedirect("ecall pulse end", 1'b0, 32'h0);
        readCsr("ecall mcause", 12'h342, 32'hB);
        readCsr("ecall mepc", 12'h341, 32'h100);
        readCsr("ecall mstatus", 12'h300, 32'h1800);
        applyStimulus();

        // Illegal instruction together with an enabled external interrupt.
        writeCsr(12'h304, 32'h800);
        writeCsr(12'h300, 32'h8);
        readCsr("mstatus MIE set", 12'h300, 32'h1808);
        exception_i = 1'b1; exception_code_i = 5'd2; exc_pc_i = 32'h140; exc_tval_i = 32'hDEAD;
        irq_ext_i = 1'b1; irq_accept_i = 1'b1; irq_pc_i = 32'h144;
        applyStimulus();
        exception_i = 1'b0;
        checkRedirect("illegal", 1'b1, 32'h200);
        applyStimulus();
        irq_accept_i = 1'b0;
        checkRedirect("illegal no nest", 1'b0, 32'h0);
        readCsr("illegal mcause", 12'h342, 32'h2);
        readCsr("illegal mtval", 12'h343, 32'hDEAD);
        readCsr("illegal mstatus", 12'h300, 32'h1880);
        readCsr("mip ext live", 12'h344, 32'h800);
        applyStimulus();

        // mret to mepc=0x104, then the held external interrupt is taken.
        writeCsr(12'h341, 32'h104);
        mret_i = 1'b1;
        applyStimulus();
        mret_i = 1'b0;
        checkRedirect("mret", 1'b1, 32'h104);
        applyStimulus();
        checkRedirect("mret pulse end", 1'b0, 32'h0);
        readCsr("mret mstatus", 12'h300, 32'h1888);
        irq_accept_i = 1'b1;
        applyStimulus();
        irq_accept_i = 1'b0; irq_ext_i = 1'b0;
        checkRedirect("ext irq", 1'b1, 32'h200);
        applyStimulus();
        readCsr("ext irq mcause", 12'h342, 32'h8000_000B);
        readCsr("ext irq mepc", 12'h341, 32'h144);
        readCsr("ext irq mtval", 12'h343, 32'h0);

        // Timer interrupt with mtvec=0x401.
        mret_i = 1'b1;
        applyStimulus();
        mret_i = 1'b0;
        checkRedirect("mret 2", 1'b1, 32'h144);
        applyStimulus();
        writeCsr(12'h304, 32'h080);
        writeCsr(12'h305, 32'h401);
`ifdef VECTORED_IRQ_EN
        readCsr("mtvec mode", 12'h305, 32'h401);
`else
        readCsr("mtvec mode", 12'h305, 32'h400);
`endif
        irq_timer_i = 1'b1; irq_accept_i = 1'b1; irq_pc_i = 32'h300;
        applyStimulus();
        irq_timer_i = 1'b0; irq_accept_i = 1'b0;
`ifdef VECTORED_IRQ_EN
        checkRedirect("timer irq", 1'b1, 32'h41C);
`else
        checkRedirect("timer irq", 1'b1, 32'h400);
`endif
        applyStimulus();
        readCsr("timer mcause", 12'h342, 32'h8000_0007);
        readCsr("timer mepc", 12'h341, 32'h300);

        // Masked or withdrawn interrupts must not trap.
        mret_i = 1'b1;
        applyStimulus();
        mret_i = 1'b0;
        applyStimulus();
        irq_sw_i = 1'b1; irq_accept_i = 1'b1;
        applyStimulus();
        checkRedirect("sw masked", 1'b0, 32'h0);
        readCsr("mip sw live", 12'h344, 32'h8);
        irq_sw_i = 1'b0; irq_accept_i = 1'b0; irq_timer_i = 1'b1;
        applyStimulus();
        checkRedirect("timer no accept", 1'b0, 32'h0);
        irq_timer_i = 1'b0; irq_accept_i = 1'b1;
        applyStimulus();
        irq_accept_i = 1'b0;
        checkRedirect("timer dropped", 1'b0, 32'h0);
        readCsr("mip idle", 12'h344, 32'h0);

        // CSR writes landing on the same edge as a trap commit.
        exception_i = 1'b1; exception_code_i = 5'd4; exc_pc_i = 32'h500; exc_tval_i = 32'h33;
        csr_we_i = 1'b1; csr_addr_i = 12'h342; csr_wdata_i = 32'h55;
        applyStimulus();
        exception_i = 1'b0; csr_we_i = 1'b0;
        checkRedirect("trap vs mcause write", 1'b1, 32'h400);
        applyStimulus();
        readCsr("trap wins mcause", 12'h342, 32'h4);
        readCsr("trap mstatus", 12'h300, 32'h1880);
        exception_i = 1'b1; exception_code_i = 5'd6; exc_pc_i = 32'h504; exc_tval_i = 32'h44;
        csr_we_i = 1'b1; csr_addr_i = 12'h304; csr_wdata_i = 32'h888;
        applyStimulus();
        exception_i = 1'b0; csr_we_i = 1'b0;
        applyStimulus();
        readCsr("mie write with trap", 12'h304, 32'h888);
        readCsr("second trap mcause", 12'h342, 32'h6);

        // Reset in the middle of a TRAP cycle.
        exception_i = 1'b1; exception_code_i = 5'd0; exc_pc_i = 32'h600; exc_tval_i = 32'h0;
        applyStimulus();
        exception_i = 1'b0;
        checkRedirect("trap before reset", 1'b1, 32'h400);
        csr_addr_i = 12'h305;
        reset_n = 1'b0;
        #1;
        checkRedirect("async reset", 1'b0, 32'h0);
        checkOutput("reset mtvec restored", csr_rdata_o, 32'h0);
        readCsr("reset mstatus again", 12'h300, 32'h1800);
        applyStimulus();
        reset_n = 1'b1;
        applyStimulus();
        checkRedirect("after reset", 1'b0, 32'h0);
        applyStimulus();

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
